hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Drives the stall/flush interface of the 5-stage pipeline register bank: pipe_stall and
//  ifid/idex/exmem/memwb_FLUSH, plus pc_WEN.
//  Resolves per cycle: halt, dcache wait, multicycle EX, branch redirect, load-use, jump, icache miss.
//  Holds state for dcache-wait and halt, and keeps a saturating stall-cycle counter.
// PARAMETERS
//  CNT_W  32  width of stall_cnt
// PORTS
//  CLK            in   1       clock, rising edge
//  nRST           in   1       reset, asynchronous, active-low
//  ihit           in   1       icache returned instruction this cycle
//  dhit           in   1       dcache completed access this cycle
//  exmem_dREN     in   1       MEM-stage load
//  exmem_dWEN     in   1       MEM-stage store
//  ex_busy        in   1       multicycle EX op not yet done
//  branch_taken   in   1       MEM-stage branch resolved taken (redirect)
//  id_jump        in   1       ID-stage jump/jr decoded
//  idex_dREN      in   1       EX-stage instruction is a load
//  idex_rd        in   5       load destination register
//  ifid_rs        in   5       ID-stage source register 1
//  ifid_rt        in   5       ID-stage source register 2
//  memwb_halt     in   1       halt instruction in WB
//  pipe_stall     out  pipe_stall_t   NO/IFID/IDEX/EXMEM/FULL_STALL (aww_types_pkg)
//  ifid_FLUSH     out  1       zero IF/ID on update
//  idex_FLUSH     out  1       zero ID/EX on update
//  exmem_FLUSH    out  1       zero EX/MEM on update
//  memwb_FLUSH    out  1       zero MEM/WB on update
//  pc_WEN         out  1       PC register write enable
//  halt           out  1       core halted (registered)
//  stall_cnt      out  CNT_W   cycles with pipe_stall != NO_STALL, saturating
// BEHAVIOUR
//  Stall semantics (consumer side):
//   - IFID_STALL: bubble into IF/ID; downstream stages advance.
//   - IDEX_STALL: bubble into ID/EX; IF/ID holds.
//   - EXMEM_STALL: bubble into EX/MEM; IF/ID and ID/EX hold.
//   - FULL_STALL: all stages hold.
//   - NO_STALL: all stages advance; flushes are honoured.
//  Decode outputs:
//   - pipe_stall, FLUSHes, and pc_WEN are combinational from registered state and current inputs.
//   - halt and stall_cnt are registered.
//  FSM states and transitions:
//   - States: RUN, DWAIT, HALT.
//   - RUN->DWAIT: (exmem_dREN|exmem_dWEN) & ~dhit.
//   - DWAIT->RUN: dhit.
//   - RUN/DWAIT->HALT: memwb_halt.
//   - HALT: exits only by reset.
//  Per-cycle priority (first match wins; unlisted FLUSH=0):
//   1. state HALT: FULL_STALL, pc_WEN=0.
//   2. memwb_halt: NO_STALL, all four FLUSH=1, pc_WEN=0, next HALT, halt<=1 next edge.
//   3. dmem pending ((dREN|dWEN)&~dhit, or DWAIT&~dhit): FULL_STALL, pc_WEN=0.
//   4. ex_busy: EXMEM_STALL, pc_WEN=0.
//   5. branch_taken: NO_STALL, ifid/idex/exmem_FLUSH=1, pc_WEN=1 (ihit ignored).
//   6. load-use: idex_dREN & idex_rd!=0 & (idex_rd==ifid_rs | idex_rd==ifid_rt).
//      Drives IDEX_STALL, pc_WEN=0.
//   7. id_jump: NO_STALL, ifid_FLUSH=1, pc_WEN=1.
//   8. ~ihit: IFID_STALL, pc_WEN=0.
//   9. else: NO_STALL, pc_WEN=1.
//  Dcache completion cycle:
//   - A cycle with dhit=1 is not a pending dmem access; rules 4-9 apply that cycle.
//  stall_cnt:
//   - Increments by 1 on each edge where pipe_stall != NO_STALL.
//   - Holds at 2^CNT_W-1.
//   - Also counts in HALT, saturating.
//  Reset (nRST=0, async):
//   - state=RUN, halt=0, stall_cnt=0.
//   - While nRST=0, outputs forced to pipe_stall=NO_STALL, FLUSHes=0, pc_WEN=0.
//   - Reset mid-DWAIT returns to RUN with no pending flush or stall.
// TESTING
//  T1 load-use:
//   - idex_dREN=1, idex_rd=5, ifid_rt=5, ihit=1.
//   - Expect IDEX_STALL, pc_WEN=0 for 1 cycle, then NO_STALL once idex_dREN=0.
//   - idex_rd=0 gives no stall.
//  T2 dcache miss:
//   - exmem_dREN=1, dhit=0 for 3 cycles, then 1.
//   - Expect FULL_STALL x3 and stall_cnt=3.
//   - On the dhit cycle, no FULL_STALL; state back in RUN.
//  T3 redirect during icache miss:
//   - branch_taken=1, ihit=0.
//   - Expect NO_STALL, ifid/idex/exmem_FLUSH=1, memwb_FLUSH=0, pc_WEN=1.
//  T4 priority:
//   - ex_busy=1 with branch_taken=1 gives EXMEM_STALL, no FLUSH.
//   - Adding a dmem miss gives FULL_STALL.
//  T5 halt:
//   - memwb_halt=1 gives all FLUSH=1 and pc_WEN=0 that cycle.
//   - Next edge: halt=1, FULL_STALL, held despite any input.
//   - nRST pulse clears halt, stall_cnt=0.
//  T6 saturation (CNT_W=4):
//   - 20 FULL_STALL cycles give stall_cnt=15, which holds.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline register bank.
// Resolves halt, dcache wait, multicycle EX, redirect, load-use, jump and icache miss each cycle.
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit_i,
  input  logic             dhit_i,
  input  logic             exmem_dREN_i,
  input  logic             exmem_dWEN_i,
  input  logic             ex_busy_i,
  input  logic             branch_taken_i,
  input  logic             id_jump_i,
  input  logic             idex_dREN_i,
  input  logic [4:0]       idex_rd_i,
  input  logic [4:0]       ifid_rs_i,
  input  logic [4:0]       ifid_rt_i,
  input  logic             memwb_halt_i,
  output logic [2:0]       pipe_stall_o,
  output logic             ifid_FLUSH_o,
  output logic             idex_FLUSH_o,
  output logic             exmem_FLUSH_o,
  output logic             memwb_FLUSH_o,
  output logic             pc_WEN_o,
  output logic             halt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  // pipe_stall_t encoding shared with the pipeline register bank
  localparam logic [2:0] NO_STALL    = 3'd0;
  localparam logic [2:0] IFID_STALL  = 3'd1;
  localparam logic [2:0] IDEX_STALL  = 3'd2;
  localparam logic [2:0] EXMEM_STALL = 3'd3;
  localparam logic [2:0] FULL_STALL  = 3'd4;

  typedef enum logic [1:0] {RUN, DWAIT, HALT} state_t;

  state_t             state_q, state_d;
  logic               halt_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dmem_req, dmem_pend, load_use;

  assign dmem_req  = exmem_dREN_i | exmem_dWEN_i;
  assign dmem_pend = ~dhit_i & (dmem_req | (state_q == DWAIT));
  assign load_use  = idex_dREN_i && (idex_rd_i != 5'd0) &&
                     ((idex_rd_i == ifid_rs_i) || (idex_rd_i == ifid_rt_i));

  always_comb begin
    pipe_stall_o  = NO_STALL;
    ifid_FLUSH_o  = 1'b0;
    idex_FLUSH_o  = 1'b0;
    exmem_FLUSH_o = 1'b0;
    memwb_FLUSH_o = 1'b0;
    pc_WEN_o      = 1'b0;
    state_d       = state_q;
    if (!nRST) begin
      state_d = RUN;
    end else if (state_q == HALT) begin
      pipe_stall_o = FULL_STALL;
    end else if (memwb_halt_i) begin
      ifid_FLUSH_o  = 1'b1;
      idex_FLUSH_o  = 1'b1;
      exmem_FLUSH_o = 1'b1;
      memwb_FLUSH_o = 1'b1;
      state_d       = HALT;
    end else begin
      // The dhit cycle completes the access, so the wait state is left immediately
      if (dmem_pend)   state_d = DWAIT;
      else if (dhit_i) state_d = RUN;

      if (dmem_pend) begin
        pipe_stall_o = FULL_STALL;
      end else if (ex_busy_i) begin
        pipe_stall_o = EXMEM_STALL;
      end else if (branch_taken_i) begin
        ifid_FLUSH_o  = 1'b1;
        idex_FLUSH_o  = 1'b1;
        exmem_FLUSH_o = 1'b1;
        pc_WEN_o      = 1'b1;
      end else if (load_use) begin
        pipe_stall_o = IDEX_STALL;
      end else if (id_jump_i) begin
        ifid_FLUSH_o = 1'b1;
        pc_WEN_o     = 1'b1;
      end else if (!ihit_i) begin
        pipe_stall_o = IFID_STALL;
      end else begin
        pc_WEN_o = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((pipe_stall_o != NO_STALL) && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      halt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      halt_q  <= (state_d == HALT);
      cnt_q   <= cnt_d;
    end
  end

  assign halt_o      = halt_q;
  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, dcache miss, redirect, priority, halt, saturation.
module tb_hazard_ctrl;

  localparam logic [2:0] NO = 3'd0, IFID = 3'd1, IDEX = 3'd2, EXMEM = 3'd3, FULL = 3'd4;

  logic       CLK, nRST;
  logic       ihit, dhit, exmem_dREN, exmem_dWEN, ex_busy, branch_taken, id_jump;
  logic       idex_dREN, memwb_halt;
  logic [4:0] idex_rd, ifid_rs, ifid_rt;
  logic [2:0] pipe_stall;
  logic       ifid_FLUSH, idex_FLUSH, exmem_FLUSH, memwb_FLUSH, pc_WEN, halt;
  logic [3:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  hazard_ctrl #(.CNT_W(4)) dut (
    .CLK(CLK), .nRST(nRST), .ihit_i(ihit), .dhit_i(dhit),
    .exmem_dREN_i(exmem_dREN), .exmem_dWEN_i(exmem_dWEN), .ex_busy_i(ex_busy),
    .branch_taken_i(branch_taken), .id_jump_i(id_jump), .idex_dREN_i(idex_dREN),
    .idex_rd_i(idex_rd), .ifid_rs_i(ifid_rs), .ifid_rt_i(ifid_rt),
    .memwb_halt_i(memwb_halt), .pipe_stall_o(pipe_stall),
    .ifid_FLUSH_o(ifid_FLUSH), .idex_FLUSH_o(idex_FLUSH), .exmem_FLUSH_o(exmem_FLUSH),
    .memwb_FLUSH_o(memwb_FLUSH), .pc_WEN_o(pc_WEN), .halt_o(halt), .stall_cnt_o(stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // flush vector is {ifid, idex, exmem, memwb}
  task automatic chk_comb(input string tag, input logic [2:0] st, input logic [3:0] fl,
                          input logic pc);
    chk({tag, ".stall"}, {29'd0, pipe_stall}, {29'd0, st});
    chk({tag, ".flush"}, {28'd0, ifid_FLUSH, idex_FLUSH, exmem_FLUSH, memwb_FLUSH},
        {28'd0, fl});
    chk({tag, ".pc_wen"}, {31'd0, pc_WEN}, {31'd0, pc});
  endtask

  task automatic chk_reg(input string tag, input logic h, input logic [3:0] c);
    chk({tag, ".halt"}, {31'd0, halt}, {31'd0, h});
    chk({tag, ".cnt"}, {28'd0, stall_cnt}, {28'd0, c});
  endtask

  task automatic idle();
    ihit = 1; dhit = 0; exmem_dREN = 0; exmem_dWEN = 0; ex_busy = 0; branch_taken = 0;
    id_jump = 0; idex_dREN = 0; memwb_halt = 0; idex_rd = 0; ifid_rs = 0; ifid_rt = 0;
  endtask

  task automatic cyc();
    @(posedge CLK); #1;
  endtask

  initial begin
    idle();
    nRST = 0;
    branch_taken = 1; memwb_halt = 1;
    #1;
    chk_comb("rst_forced", NO, 4'b0000, 0);
    chk_reg("rst_state", 0, 4'd0);
    cyc(); cyc();
    nRST = 1; idle();
    #1; chk_comb("run_idle", NO, 4'b0000, 1);
    cyc(); chk_reg("run_idle_r", 0, 4'd0);

    // T1 load-use
    idex_dREN = 1; idex_rd = 5; ifid_rt = 5; ifid_rs = 2;
    #1; chk_comb("lu_rt", IDEX, 4'b0000, 0);
    cyc(); chk_reg("lu_rt_r", 0, 4'd1);
    idex_dREN = 0;
    #1; chk_comb("lu_clear", NO, 4'b0000, 1);
    cyc(); chk_reg("lu_clear_r", 0, 4'd1);
    idex_dREN = 1; idex_rd = 0; ifid_rs = 0; ifid_rt = 0;
    #1; chk_comb("lu_r0", NO, 4'b0000, 1);
    cyc();
    idex_rd = 7; ifid_rs = 7; ifid_rt = 3;
    #1; chk_comb("lu_rs", IDEX, 4'b0000, 0);
    cyc(); chk_reg("lu_rs_r", 0, 4'd2);
    idle();

    // icache miss, then jump over a miss
    ihit = 0;
    #1; chk_comb("imiss", IFID, 4'b0000, 0);
    cyc(); chk_reg("imiss_r", 0, 4'd3);
    id_jump = 1;
    #1; chk_comb("jump", NO, 4'b1000, 1);
    cyc(); idle();

    // T3 redirect during icache miss, with a load-use also present
    branch_taken = 1; ihit = 0; idex_dREN = 1; idex_rd = 4; ifid_rs = 4;
    #1; chk_comb("redirect", NO, 4'b1110, 1);
    cyc(); chk_reg("redirect_r", 0, 4'd3);
    idle();

    // T4 priority
    ex_busy = 1; branch_taken = 1;
    #1; chk_comb("busy_over_br", EXMEM, 4'b0000, 0);
    cyc(); chk_reg("busy_r", 0, 4'd4);
    exmem_dREN = 1; dhit = 0;
    #1; chk_comb("dmiss_over_busy", FULL, 4'b0000, 0);
    cyc(); chk_reg("dmiss_busy_r", 0, 4'd5);

    // reset while in DWAIT returns to RUN with no pending stall
    idle(); nRST = 0;
    #1; chk_comb("rst_dwait", NO, 4'b0000, 0);
    chk_reg("rst_dwait_r", 0, 4'd0);
    cyc(); nRST = 1;
    #1; chk_comb("post_rst_run", NO, 4'b0000, 1);
    cyc();

    // T2 dcache miss for 3 cycles
    exmem_dREN = 1; dhit = 0;
    for (int i = 1; i <= 3; i++) begin
      #1; chk_comb($sformatf("dmiss%0d", i), FULL, 4'b0000, 0);
      cyc(); chk_reg($sformatf("dmiss%0d_r", i), 0, i[3:0]);
    end
    dhit = 1;
    #1; chk_comb("dhit_cycle", NO, 4'b0000, 1);
    cyc(); chk_reg("dhit_r", 0, 4'd3);
    idle();
    #1; chk_comb("back_in_run", NO, 4'b0000, 1);
    cyc();
    exmem_dWEN = 1; dhit = 1; ex_busy = 1;
    #1; chk_comb("dhit_busy", EXMEM, 4'b0000, 0);
    cyc(); chk_reg("dhit_busy_r", 0, 4'd4);
    idle();

    // T5 halt beats a pending dmem miss
    memwb_halt = 1; exmem_dREN = 1; dhit = 0;
    #1; chk_comb("halt_cycle", NO, 4'b1111, 0);
    chk_reg("halt_pre", 0, 4'd4);
    cyc(); chk_reg("halt_set", 1, 4'd4);
    idle();
    #1; chk_comb("halted", FULL, 4'b0000, 0);

    // T6 saturation while halted, with disruptive inputs
    branch_taken = 1; id_jump = 1; ihit = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (i == 19) chk_comb("halt_hold", FULL, 4'b0000, 0);
    end
    chk_reg("saturated", 1, 4'd15);
    cyc(); chk_reg("sat_hold", 1, 4'd15);

    idle(); nRST = 0;
    #1; chk_reg("halt_clear", 0, 4'd0);
    chk_comb("halt_rst_forced", NO, 4'b0000, 0);
    cyc(); nRST = 1;
    #1; chk_comb("after_halt_rst", NO, 4'b0000, 1);
    cyc(); chk_reg("after_halt_rst_r", 0, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
